// File: rtl/panda_mem_arbiter.sv
// Two-port (fetch + LSU) to one-port arbiter for a shared panda_ram; data wins conflicts.
// Optional fetch-starvation guard enabled by `define PANDA_MEM_ARB_STARVE_GUARD_EN.
module panda_mem_arbiter #(
  parameter int AddrWidth   = 10,
  parameter int ReadLatency = 1,
  parameter int MaxStall    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 mem_ce_o,
  output logic [3:0]           mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i
);

  localparam int          Tail     = ReadLatency - 1;
  localparam logic [3:0]  StallMax = 4'(MaxStall);

  logic                 w_instr_gnt, w_data_gnt, w_force;
  logic                 w_ce;
  logic [3:0]           w_we;
  logic [AddrWidth-1:0] w_addr;
  logic [31:0]          w_wdata;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? lim : cnt + 4'd1;
  endfunction

`ifdef PANDA_MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_stall_cnt;

  assign w_force = instr_req_i & data_req_i & (r_stall_cnt == StallMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (instr_req_i && !w_instr_gnt) begin
      r_stall_cnt <= sat_inc(r_stall_cnt, StallMax);
    end else begin
      r_stall_cnt <= '0;
    end
  end
`else
  logic w_unused_stall;
  assign w_force        = 1'b0;
  assign w_unused_stall = ^{StallMax, sat_inc(4'd0, 4'd0)};
`endif

  assign w_data_gnt  = data_req_i & ~w_force;
  assign w_instr_gnt = instr_req_i & ~w_data_gnt;
  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;

  always_comb begin
    w_ce    = 1'b0;
    w_we    = 4'b0;
    w_addr  = '0;
    w_wdata = 32'b0;
    if (w_data_gnt) begin
      w_ce    = 1'b1;
      w_we    = data_we_i ? data_be_i : 4'b0;
      w_addr  = data_addr_i[AddrWidth+1:2];
      w_wdata = data_wdata_i;
    end else if (w_instr_gnt) begin
      w_ce    = 1'b1;
      w_addr  = instr_addr_i[AddrWidth+1:2];
    end
  end

  // Memory drive is forced quiet while reset is held; grants stay live.
  assign mem_ce_o   = w_ce & rst_ni;
  assign mem_we_o   = w_we & {4{rst_ni}};
  assign mem_addr_o = w_addr & {AddrWidth{rst_ni}};
  assign mem_data_o = w_wdata & {32{rst_ni}};

  logic                   w_push_vld, w_push_own, w_push_st;
  logic [ReadLatency-1:0] w_vld_n, w_own_n, w_st_n;
  logic [ReadLatency-1:0] r_vld_p, r_own_p, r_st_p;

  assign w_push_vld = w_instr_gnt | w_data_gnt;
  assign w_push_own = w_data_gnt;
  assign w_push_st  = w_data_gnt & data_we_i;

  generate
    if (ReadLatency == 1) begin : g_shift1
      assign w_vld_n = w_push_vld;
      assign w_own_n = w_push_own;
      assign w_st_n  = w_push_st;
    end else begin : g_shiftn
      assign w_vld_n = {r_vld_p[ReadLatency-2:0], w_push_vld};
      assign w_own_n = {r_own_p[ReadLatency-2:0], w_push_own};
      assign w_st_n  = {r_st_p[ReadLatency-2:0], w_push_st};
    end
  endgenerate

  // Response pipeline: {valid, owner (1 = data), is_store}, tail at index Tail.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_p <= '0;
      r_own_p <= '0;
      r_st_p  <= '0;
    end else begin
      r_vld_p <= w_vld_n;
      r_own_p <= w_own_n;
      r_st_p  <= w_st_n;
    end
  end

  assign instr_rvalid_o = r_vld_p[Tail] & ~r_own_p[Tail];
  assign data_rvalid_o  = r_vld_p[Tail] & r_own_p[Tail];
  assign instr_rdata_o  = instr_rvalid_o ? mem_data_i : 32'b0;
  assign data_rdata_o   = (data_rvalid_o && !r_st_p[Tail]) ? mem_data_i : 32'b0;

  logic w_unused_addr;
  assign w_unused_addr = ^{instr_addr_i[31:AddrWidth+2], instr_addr_i[1:0],
                           data_addr_i[31:AddrWidth+2], data_addr_i[1:0]};

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Scoreboard bench for panda_mem_arbiter: one stimulus stream drives a ReadLatency=1
// and a ReadLatency=2 instance sharing one RAM model; a monitor checks responses.
module tb_panda_mem_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic        ir, dr, dwe;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dbe;

  logic        igt1, irv1, dgt1, drv1, ce1;
  logic [31:0] ird1, drd1, mdo1;
  logic [3:0]  we1;
  logic [9:0]  addr1;
  logic        igt2, irv2, dgt2, drv2, ce2;
  logic [31:0] ird2, drd2, mdo2;
  logic [3:0]  we2;
  logic [9:0]  addr2;
  logic [31:0] q1, q2;

  panda_mem_arbiter #(.AddrWidth(10), .ReadLatency(1), .MaxStall(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igt1),
    .instr_rvalid_o(irv1), .instr_rdata_o(ird1),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
    .data_wdata_i(dwd), .data_gnt_o(dgt1), .data_rvalid_o(drv1), .data_rdata_o(drd1),
    .mem_ce_o(ce1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_data_o(mdo1),
    .mem_data_i(q1));

  panda_mem_arbiter #(.AddrWidth(10), .ReadLatency(2), .MaxStall(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igt2),
    .instr_rvalid_o(irv2), .instr_rdata_o(ird2),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
    .data_wdata_i(dwd), .data_gnt_o(dgt2), .data_rvalid_o(drv2), .data_rdata_o(drd2),
    .mem_ce_o(ce2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_data_o(mdo2),
    .mem_data_i(q2));

  // Shared RAM: q1 is the one-cycle read port, q2 adds an output register.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (ce1) begin
      for (int b = 0; b < 4; b++)
        if (we1[b]) mem[addr1][8*b +: 8] <= mdo1[8*b +: 8];
      if (we1 == 4'b0) q1 <= mem[addr1];
    end
    q2 <= q1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t sb [4][$];   // 0: instr RL1, 1: data RL1, 2: instr RL2, 3: data RL2

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input string nm);
    exp_t e;
    if (rv) begin
      if (sb[p].size() == 0) begin
        chk({nm, "_unexpected_rvalid"}, 32'd1, 32'd0);
      end else begin
        e = sb[p].pop_front();
        chk({nm, "_rdata"}, rd, e.d);
        chk({nm, "_cycle"}, cyc, e.c);
      end
    end else begin
      chk({nm, "_idle_rdata"}, rd, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0, irv1, ird1, "instr_rl1");
      mon_port(1, drv1, drd1, "data_rl1");
      mon_port(2, irv2, ird2, "instr_rl2");
      mon_port(3, drv2, drd2, "data_rl2");
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_instr_rvalid"}, {irv1, irv2}, 0);
    chk({nm, "_data_rvalid"}, {drv1, drv2}, 0);
    chk({nm, "_rdata_rl1"}, ird1 | drd1, 0);
    chk({nm, "_rdata_rl2"}, ird2 | drd2, 0);
    chk({nm, "_mem_ce_we"}, {ce1, we1, ce2, we2}, 0);
    chk({nm, "_mem_addr"}, {addr1, addr2}, 0);
    chk({nm, "_mem_data"}, mdo1 | mdo2, 0);
  endtask

  // One cycle of stimulus with the hand-computed grant and response values.
  task automatic step(input logic ir_, input logic [31:0] ia_,
                      input logic dr_, input logic dwe_, input logic [3:0] dbe_,
                      input logic [31:0] da_, input logic [31:0] dwd_,
                      input logic egi, input logic egd,
                      input logic [31:0] eri, input logic [31:0] erd, input bit push);
    logic [9:0]  ea;
    logic [3:0]  ew;
    logic [31:0] ed;
    ir = ir_; ia = ia_; dr = dr_; dwe = dwe_; dbe = dbe_; da = da_; dwd = dwd_;
    #1;
    ea = 10'd0; ew = 4'd0; ed = 32'd0;
    if (egd) begin
      ea = da_[11:2]; ew = dwe_ ? dbe_ : 4'd0; ed = dwd_;
    end else if (egi) begin
      ea = ia_[11:2];
    end
    chk("instr_gnt_rl1", igt1, egi);
    chk("data_gnt_rl1", dgt1, egd);
    chk("instr_gnt_rl2", igt2, egi);
    chk("data_gnt_rl2", dgt2, egd);
    chk("mem_ce", ce1, egi | egd);
    chk("mem_addr", addr1, ea);
    chk("mem_we", we1, ew);
    chk("mem_data", mdo1, ed);
    chk("mem_addr_rl2", addr2, ea);
    if (push) begin
      if (egi) begin
        sb[0].push_back('{d: eri, c: cyc + 1});
        sb[2].push_back('{d: eri, c: cyc + 2});
      end
      if (egd) begin
        sb[1].push_back('{d: erd, c: cyc + 1});
        sb[3].push_back('{d: erd, c: cyc + 2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    bit pend, gi;
    ir = 0; ia = 0; dr = 0; dwe = 0; dbe = 0; da = 0; dwd = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEAD_BEEF;
    mem[5] = 32'hAAAA_BBBB;
    mem[7] = 32'h1111_2222;
    mem[9] = 32'h3333_4444;

    // Reset with a fetch request held: granted combinationally, no memory access.
    #2 rst_ni = 1'b0;
    ir = 1'b1; ia = 32'h8;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("rst_instr_gnt", igt1, 1'b1);
    chk("rst_instr_gnt_rl2", igt2, 1'b1);
    chk_zero("rst");
    @(posedge clk);
    @(negedge clk);
    ir = 1'b0; ia = 32'h0;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_zero("after_rst");

    step(1, 32'h8, 0, 0, 4'b0000, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1);
    step(0, 0, 1, 1, 4'b0011, 32'h14, 32'h1234_5678, 0, 1, 0, 32'h0, 1);
    step(0, 0, 1, 0, 4'b0000, 32'h14, 0, 0, 1, 0, 32'hAAAA_5678, 1);
    step(0, 0, 1, 0, 4'b0000, 32'hFFFF_F017, 0, 0, 1, 0, 32'hAAAA_5678, 1);
    idle(1);

    // Conflict: data wins, fetch granted once data drops.
    step(1, 32'h1C, 1, 0, 4'b0000, 32'h24, 0, 0, 1, 0, 32'h3333_4444, 1);
    step(1, 32'h1C, 0, 0, 4'b0000, 0, 0, 1, 0, 32'h1111_2222, 0, 1);
    idle(1);

    // Alternating back-to-back grants.
    step(1, 32'h8, 0, 0, 4'b0000, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1);
    step(0, 0, 1, 0, 4'b0000, 32'h24, 0, 0, 1, 0, 32'h3333_4444, 1);
    step(1, 32'h1C, 0, 0, 4'b0000, 0, 0, 1, 0, 32'h1111_2222, 0, 1);
    idle(3);

    // Continuous data traffic with a fetch held pending.
    pend = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef PANDA_MEM_ARB_STARVE_GUARD_EN
      gi = (k == 4);
`else
      gi = 1'b0;
`endif
      step(pend, 32'h8, 1, 0, 4'b0000, 32'h24, 0, gi, !gi, 32'hDEAD_BEEF, 32'h3333_4444, 1);
      if (gi) pend = 1'b0;
    end
    if (pend) step(1, 32'h8, 0, 0, 4'b0000, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1);
    idle(3);

    // Reset one cycle after a grant: the response must never appear.
    step(1, 32'h8, 0, 0, 4'b0000, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
    rst_ni = 1'b0;
    ir = 1'b0; ia = 32'h0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    chk_zero("mid_rst_held");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_zero("mid_rst_release");
    idle(4);

    for (int p = 0; p < 4; p++) chk($sformatf("drain_q%0d", p), sb[p].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/panda_mem_arbiter.md
# panda_mem_arbiter

Two-port to one-port arbiter that lets the instruction fetch path and the load-store unit share a single `panda_ram` instance (unified instruction/data memory). It sits between the controller's fetch port, the datapath's LSU port, and the memory. It grants at most one access per cycle and returns each response to its owner after the fixed memory read latency. Data accesses have priority over fetch; an optional guard bounds fetch starvation.

## Interface
- `AddrWidth`, default 10: memory word-address width; memory depth is 2^AddrWidth words.
- `ReadLatency`, default 1: memory read latency in cycles. Legal values are 1 (`OutputReg=0`) and 2 (`OutputReg=1`).
- `MaxStall`, default 4: consecutive denied fetch cycles before fetch is forced; 1..15; used only with the guard macro.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in 32: fetch byte address.
- `instr_gnt_o` out 1: fetch request accepted this cycle.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out 32: fetch read data.
- `data_req_i` in 1: LSU request.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_be_i` in 4: store byte enables.
- `data_addr_i` in 32: LSU byte address.
- `data_wdata_i` in 32: store data.
- `data_gnt_o` out 1: LSU request accepted.
- `data_rvalid_o` out 1: LSU response valid (loads and stores).
- `data_rdata_o` out 32: load data.
- `mem_ce_o` out 1: memory chip enable.
- `mem_we_o` out 4: memory byte write enables.
- `mem_addr_o` out AddrWidth: memory word address.
- `mem_data_o` out 32: memory write data.
- `mem_data_i` in 32: memory read data.

## Operation
- **Handshake.** A requester raises req with address/data stable and holds them until gnt. gnt is combinational in the same cycle. A new request may be presented the cycle after gnt.
- **Arbitration.**
  - Only one requester active: it is granted.
  - Both active: data wins, unless the starvation guard fires (see Configuration).
  - Neither active: `mem_ce_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- **Memory drive.**
  - `mem_addr_o` = winner addr[AddrWidth+1:2]; addr[1:0] and bits above AddrWidth+1 are ignored.
  - `mem_ce_o` = 1 on any grant.
  - `mem_we_o` = `data_be_i` only for a granted store, otherwise 0.
  - `mem_data_o` = `data_wdata_i` when data is granted, otherwise 0.
- **Response pipeline.** A ReadLatency-deep shift register of {valid, owner, is_store} is pushed every cycle.
  - At the tail, the owner's rvalid pulses for one cycle.
  - For a load or fetch, rdata = `mem_data_i`; for a store, rdata = 0.
  - The non-owner's rdata is 0.
- **Stall counter.** 4-bit `stall_cnt` (guard builds only):
  - increments, saturating at MaxStall, when `instr_req_i`=1 and `instr_gnt_o`=0;
  - clears when fetch is granted or `instr_req_i`=0.
- **Reset** (any time, including mid-transaction):
  - pipeline flushed and in-flight responses discarded;
  - `stall_cnt`=0;
  - all outputs 0 except gnt, which stays combinational from the inputs, so an asserted req during reset is still granted combinationally but no response is produced.

## Timing
- Request/grant decision: 0 cycles (combinational).
- Response: rvalid exactly ReadLatency cycles after the grant cycle, in grant order.
- Throughput: one access per cycle; back-to-back grants to either or alternating requesters are allowed with no bubble.
- Fetch under continuous data traffic:
  - with the guard: at most MaxStall denied cycles, granted on cycle MaxStall+1;
  - without the guard: unbounded.
- Reset values: `instr_rvalid_o`=`data_rvalid_o`=0, both rdata=0, all `mem_*` outputs=0.

## Configuration
- Macro `PANDA_MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** when both request and `stall_cnt`==MaxStall, fetch wins that cycle, data is denied, and the counter clears.
- **Undefined:** no counter is built, data always wins on conflict, and MaxStall is unused.

## Test plan
- **Fetch read.** Reset, ReadLatency=1. Fetch req addr 0x0000_0008 with mem word 2=0xDEAD_BEEF → `instr_gnt_o`=1, `mem_addr_o`=2, `mem_we_o`=0. Next cycle `instr_rvalid_o`=1, `instr_rdata_o`=0xDEAD_BEEF, `data_rvalid_o`=0.
- **Store.** Data store addr 0x14, be 4'b0011, wdata 0x1234_5678 → `mem_we_o`=4'b0011, `mem_addr_o`=5. Next cycle `data_rvalid_o`=1, `data_rdata_o`=0. A later load of addr 0x14 returns 0x????_5678 in the low half.
- **Conflict.** Both request in the same cycle with guard undefined → `data_gnt_o`=1, `instr_gnt_o`=0. Fetch is granted the first cycle `data_req_i` drops.
- **Starvation guard.** Guard defined, MaxStall=4, data requests every cycle, fetch held → `instr_gnt_o`=0 for 4 cycles, 1 on cycle 5 with `data_gnt_o`=0 that cycle, then data resumes.
- **Alternating, ReadLatency=2.** Fetch, data, fetch granted on cycles 0, 1, 2 → rvalid on cycles 2 (instr), 3 (data), 4 (instr), each with matching rdata.
- **Reset mid-flight.** Assert `rst_ni`=0 one cycle after a grant with ReadLatency=2 → no rvalid is ever produced for that grant, and all outputs read 0 after reset release.
